// File: rtl/key_event_encoder.sv
// key_event_encoder: debounce a 103-key matrix and queue make/break events.
// Ports: clock/reset (async, active-high); enabled gates the key walker;
// key_down[103:1] raw key state; evt_valid/evt_ready/evt_code/evt_make
// present the FIFO head; fifo_count is the queue occupancy.
// Optional macro KEY_EVENT_STATE_OUT_EN adds key_state[103:1] (debounced bits).
module key_event_encoder #(
  parameter int DEB_CNT = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enabled,
  input  logic [103:1] key_down,
  output logic         evt_valid,
  input  logic         evt_ready,
  output logic [6:0]   evt_code,
  output logic         evt_make,
  output logic [4:0]   fifo_count
`ifdef KEY_EVENT_STATE_OUT_EN
  ,
  output logic [103:1] key_state
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [6:0] idx;
  logic [103:1] stable;
  logic [1:0] cnt [1:103];
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic step, cur, differ, settle, push, pop;
  logic [2:0] cnt_next;
  // The walker stalls while full so a settling key can never lose its event.
  always_comb begin
    step = enabled && (fifo_count != 5'(FIFO_DEPTH));
    cur = key_down[idx];
    differ = cur != stable[idx];
    cnt_next = {1'b0, cnt[idx]} + 3'd1;
    settle = differ && (cnt_next == 3'(DEB_CNT));
    push = step && settle;
    pop = evt_valid && evt_ready;
  end
  assign evt_valid = fifo_count != 5'd0;
  assign {evt_code, evt_make} = evt_valid ? mem[rd_ptr] : 8'd0;
`ifdef KEY_EVENT_STATE_OUT_EN
  assign key_state = stable;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      idx <= 7'd1;
      stable <= '0;
      for (int i = 1; i <= 103; i++) cnt[i] <= 2'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= 5'd0;
    end else begin
      if (step) begin
        idx <= idx == 7'd103 ? 7'd1 : idx + 7'd1;
        cnt[idx] <= (settle || !differ) ? 2'd0 : cnt_next[1:0];
        if (settle) stable[idx] <= cur;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + 5'(push) - 5'(pop);
    end
  // Payload storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= {idx, cur};
endmodule

// File: tb/tb_key_event_encoder.sv
// tb_key_event_encoder: scoreboard bench for key_event_encoder with a reference model.
module tb_key_event_encoder;
  localparam int DEB = 3;
  localparam int DEPTH = 8;
  logic clock = 0, reset = 1, enabled = 0, evt_ready = 0;
  logic [103:1] key_down = '0;
  logic evt_valid, evt_make;
  logic [6:0] evt_code;
  logic [4:0] fifo_count;
`ifdef KEY_EVENT_STATE_OUT_EN
  logic [103:1] key_state;
  logic [103:1] st_vec;
`endif
  key_event_encoder #(.DEB_CNT(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .enabled(enabled), .key_down(key_down),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_make(evt_make), .fifo_count(fifo_count)
`ifdef KEY_EVENT_STATE_OUT_EN
    , .key_state(key_state)
`endif
  );
  always #5 clock = ~clock;
  typedef struct {int code; bit make;} ev_t;
  ev_t mq[$];
  ev_t sb[$];
  ev_t e, last;
  int w = 1;
  bit st [1:103];
  int c [1:103];
  bit m_pop;
  int vectors = 0, errors = 0, handshakes = 0;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: debounce each visited key, queue its event, track occupancy.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      w = 1;
      for (int i = 1; i <= 103; i++) begin st[i] = 0; c[i] = 0; end
      mq.delete();
      sb.delete();
    end else begin
      m_pop = mq.size() > 0 && evt_ready;
      if (enabled && mq.size() < DEPTH) begin
        if (key_down[w] == st[w]) c[w] = 0;
        else if (c[w] + 1 == DEB) begin
          st[w] = key_down[w];
          c[w] = 0;
          mq.push_back('{w, key_down[w]});
          sb.push_back('{w, key_down[w]});
        end else c[w]++;
        w = w % 103 + 1;
      end
      if (m_pop) void'(mq.pop_front());
    end
  end
  // Monitor: inputs change only just after rising edges, so negedge values hold at the next edge.
  always @(negedge clock) if (!reset) begin
    chk("fifo_count", int'(fifo_count), mq.size());
    chk("evt_valid", int'(evt_valid), int'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("head_code", int'(evt_code), mq[0].code);
      chk("head_make", int'(evt_make), int'(mq[0].make));
    end
    if (evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL pop_unexpected: code %0d make %0d with empty scoreboard", evt_code, evt_make);
      end else begin
        e = sb.pop_front();
        chk("pop_code", int'(evt_code), e.code);
        chk("pop_make", int'(evt_make), int'(e.make));
        last = e;
        handshakes++;
      end
    end
`ifdef KEY_EVENT_STATE_OUT_EN
    for (int i = 1; i <= 103; i++) st_vec[i] = st[i];
    vectors++;
    if (key_state !== st_vec) begin
      errors++;
      $display("FAIL key_state: got %h expected %h", key_state, st_vec);
    end
`endif
  end
  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask
  initial begin
    tick(2);
    chk("reset_valid", int'(evt_valid), 0);
    chk("reset_count", int'(fifo_count), 0);
    chk("reset_code", int'(evt_code), 0);
    reset = 0;
    enabled = 1;
    evt_ready = 1;
    key_down[5] = 1;
    tick(515);
    chk("req030_events", handshakes, 1);
    chk("req030_code", last.code, 5);
    chk("req030_make", int'(last.make), 1);
`ifdef KEY_EVENT_STATE_OUT_EN
    chk("req035_bit5", int'(key_state[5]), 1);
    chk("req035_others", int'(key_state == 103'(1) << 4), 1);
`endif
    for (int i = 0; i < 300 && w != 41; i++) tick(1);
    key_down[40] = 1;
    tick(103);
    key_down[40] = 0;
    tick(206);
    chk("req031_events", handshakes, 1);
    key_down[5] = 0;
    tick(400);
    chk("release5_events", handshakes, 2);
    evt_ready = 0;
    key_down[10:1] = '1;
    tick(412);
    chk("req032_full", int'(fifo_count), 8);
    tick(50);
    chk("req032_stall", int'(fifo_count), 8);
    evt_ready = 1;
    tick(400);
    chk("req032_events", handshakes, 12);
    chk("req032_last", last.code, 10);
    key_down[10:1] = '0;
    tick(400);
    chk("release10_events", handshakes, 22);
    key_down[103] = 1;
    tick(400);
    chk("req033_make_code", last.code, 103);
    chk("req033_make", int'(last.make), 1);
    key_down[103] = 0;
    tick(400);
    chk("req033_events", handshakes, 24);
    chk("req033_break", int'(last.make), 0);
    evt_ready = 0;
    key_down[22:20] = '1;
    tick(400);
    chk("req034_queued", int'(fifo_count), 3);
    #1 reset = 1;
    #1;
    chk("req034_valid", int'(evt_valid), 0);
    chk("req034_count", int'(fifo_count), 0);
    chk("req034_code", int'(evt_code), 0);
    tick(2);
    reset = 0;
    evt_ready = 1;
    tick(400);
    chk("req027_events", handshakes, 27);
    key_down = '0;
    tick(400);
    chk("release_held", handshakes, 30);
    for (int r = 0; r < 50; r++) begin
      repeat ($urandom_range(1, 3)) key_down[$urandom_range(1, 103)] ^= 1'b1;
      repeat ($urandom_range(50, 300)) begin
        evt_ready = $urandom_range(0, 3) != 0;
        enabled = $urandom_range(0, 9) != 0;
        tick(1);
      end
    end
    evt_ready = 1;
    enabled = 1;
    tick(1000);
    chk("drain_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
